// File: rtl/bm_bcd_pkg.sv
// Shared constants and types for the sequential binary-to-BCD converter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: FSM state encoding, add-3 correction threshold, blank nibble
// used for out-of-range digit selects, and default sizing parameters.
package bm_bcd_pkg;

  localparam int DEF_BIN_W  = 16;
  localparam int DEF_DIGITS = 5;
  localparam int DEF_IDX_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // A BCD digit at or above this value would exceed 9 after doubling,
  // so it gets +3 before the next shift.
  localparam logic [3:0] ADD3_THRESHOLD = 4'd5;

  // Drives the downstream seven-segment decoder into its default pattern.
  localparam logic [3:0] BLANK_NIBBLE = 4'hF;

endpackage : bm_bcd_pkg

// File: rtl/bm_bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input nibble.
//
// Ports:
//   digit     - current scratch BCD digit (0..9 in normal operation)
//   corrected - digit + 3 when digit >= 5, otherwise digit unchanged
module bm_bcd_add3
  import bm_bcd_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] corrected
);

  // Inputs are always 0..9 during a conversion, so the 4-bit sum never wraps.
  assign corrected = (digit >= ADD3_THRESHOLD) ? digit + 4'd3 : digit;

endmodule : bm_bcd_add3

// File: rtl/bm_bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one binary bit per clock.
// Latency: start accepted at edge k -> bcd_out/done valid after edge k+BIN_W+1.
// Backpressure: none queued; start is ignored while busy, bin sampled only on acceptance.
//
// Ports:
//   clock, reset_n - rising-edge clock, asynchronous active-low reset
//   start, bin     - conversion request and binary operand (sampled in IDLE)
//   busy, done     - conversion in flight / one-cycle result-valid pulse
//   bcd_out        - registered packed BCD result, digit 0 in bits [3:0]
//   digit_idx      - digit select for bcd_digit
//   bcd_digit      - selected BCD nibble, BLANK_NIBBLE when digit_idx >= DIGITS
module bm_bin2bcd_seq
  import bm_bcd_pkg::*;
#(
  parameter int BIN_W  = DEF_BIN_W,
  parameter int DIGITS = DEF_DIGITS,
  parameter int IDX_W  = DEF_IDX_W
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  input  logic [IDX_W-1:0]      digit_idx,
  output logic [3:0]            bcd_digit
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  state_t               state;
  logic [BCD_W-1:0]     scratch;
  logic [BIN_W-1:0]     bin_sr;
  logic [CNT_W-1:0]     bit_cnt;

  logic [BCD_W-1:0]       adj;
  logic [BCD_W+BIN_W-1:0] cat_shifted;

  // Per-digit add-3 correction applied to the scratch before every shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bm_bcd_add3 u_add3 (
      .digit     (scratch[4*g +: 4]),
      .corrected (adj[4*g +: 4])
    );
  end

  // One double-dabble step: the binary MSB moves into scratch bit 0.
  // The top bit of the corrected scratch falls off; it is provably zero
  // because 10^DIGITS exceeds the binary range.
  assign cat_shifted = {adj, bin_sr} << 1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd_out <= '0;
      scratch <= '0;
      bin_sr  <= '0;
      bit_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_sr  <= bin;
            scratch <= '0;
            bit_cnt <= CNT_W'(BIN_W - 1);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= cat_shifted[BCD_W+BIN_W-1 -: BCD_W];
          bin_sr  <= cat_shifted[BIN_W-1:0];
          if (bit_cnt == '0) begin
            state <= DONE;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        DONE: begin
          // Only point where bcd_out changes, so it never shows partial sums.
          bcd_out <= scratch;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Digit select feeding the seven-segment decoder; out-of-range selects blank.
  always_comb begin
    bcd_digit = BLANK_NIBBLE;
    for (int i = 0; i < DIGITS; i++) begin
      if (digit_idx == IDX_W'(i)) begin
        bcd_digit = bcd_out[4*i +: 4];
      end
    end
  end

endmodule : bm_bin2bcd_seq

// File: tb/tb_bm_bin2bcd_seq.sv
// Self-checking bench for bm_bin2bcd_seq: directed scenarios plus random conversions.
// Latency: expects results BIN_W+1 edges after the accepting edge.
// Backpressure: exercises ignored start while busy and start in the done cycle.
module tb_bm_bin2bcd_seq;

  localparam int BIN_W  = 16;
  localparam int DIGITS = 5;
  localparam int IDX_W  = 3;

  logic                clock;
  logic                reset_n;
  logic                start;
  logic [BIN_W-1:0]    bin;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd_out;
  logic [IDX_W-1:0]    digit_idx;
  logic [3:0]          bcd_digit;

  int checks = 0;
  int errors = 0;

  bm_bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS), .IDX_W(IDX_W)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .start     (start),
    .bin       (bin),
    .busy      (busy),
    .done      (done),
    .bcd_out   (bcd_out),
    .digit_idx (digit_idx),
    .bcd_digit (bcd_digit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Decimal digits of v, packed 4 bits per digit, units first.
  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] exp_digit(input int v, input int idx);
    int x;
    if (idx >= DIGITS) return 4'hF;
    x = v;
    for (int i = 0; i < idx; i++) x = x / 10;
    return 4'(x % 10);
  endfunction

  // Transaction-level model: a request seen while idle produces its decimal
  // value BIN_W+1 edges later; busy covers that whole window.
  int  m_left;
  int  m_val;
  int  m_last;
  bit  m_busy;
  bit  m_done;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_left = 0; m_val = 0; m_last = 0; m_busy = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_left != 0) begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_done = 1;
          m_busy = 0;
          m_last = m_val;
        end
      end else if (start) begin
        m_val  = int'(bin);
        m_left = BIN_W + 1;
        m_busy = 1;
      end
    end
  end

  // Cycle-by-cycle comparison on the falling edge.
  bit prev_done = 0;
  always @(negedge clock) begin
    if (reset_n) begin
      chk("busy", 32'(busy), 32'(m_busy));
      chk("done", 32'(done), 32'(m_done));
      chk("bcd_out", 32'(bcd_out), 32'(to_bcd(m_last)));
      chk("bcd_digit", 32'(bcd_digit), 32'(exp_digit(m_last, int'(digit_idx))));
      chk("done_width", 32'(done && prev_done), 32'd0);
      chk("busy_done_overlap", 32'(busy && done), 32'd0);
      prev_done = done;
    end else begin
      prev_done = 0;
    end
  end

  task automatic wait_done(input int limit, output int n, output int busy_n);
    bit found;
    found  = 0;
    n      = 0;
    busy_n = 0;
    while (!found && n < limit) begin
      @(posedge clock); #1;
      n++;
      if (busy) busy_n++;
      if (done) found = 1;
    end
    chk("done_timeout", 32'(found), 32'd1);
  endtask

  task automatic accept(input logic [BIN_W-1:0] v);
    bin   = v;
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  int n, bn, dcount;
  logic [3:0] sweep [8];

  initial begin
    reset_n   = 1'b0;
    start     = 1'b0;
    bin       = '0;
    digit_idx = '0;

    // Pin the model with hand-computed values.
    chk("model_0",     32'(to_bcd(0)),     32'h00000);
    chk("model_65535", 32'(to_bcd(65535)), 32'h65535);
    chk("model_1234",  32'(to_bcd(1234)),  32'h01234);
    chk("model_40960", 32'(to_bcd(40960)), 32'h40960);
    chk("model_digit", 32'(exp_digit(65535, 4)), 32'h6);

    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd",  32'(bcd_out), 32'd0);
    #10 reset_n = 1'b1;
    @(posedge clock); #1;

    // Zero: latency and busy window.
    accept(16'd0);
    bn = 0;
    if (busy) bn = 1;
    wait_done(40, n, dcount);
    chk("zero_latency", 32'(n), 32'd17);
    chk("zero_busy_cycles", 32'(bn + dcount), 32'd17);
    chk("zero_bcd", 32'(bcd_out), 32'h00000);

    // Full-scale value and digit sweep.
    accept(16'd65535);
    wait_done(40, n, bn);
    chk("max_bcd", 32'(bcd_out), 32'h65535);
    sweep = '{4'h5, 4'h3, 4'h5, 4'h5, 4'h6, 4'hF, 4'hF, 4'hF};
    for (int i = 0; i < 8; i++) begin
      digit_idx = 3'(i);
      #1;
      chk($sformatf("sweep_idx%0d", i), 32'(bcd_digit), 32'(sweep[i]));
    end
    digit_idx = '0;

    // Second start while busy is dropped.
    accept(16'd1234);
    repeat (4) @(posedge clock);
    #1;
    bin = 16'd9999; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(40, n, bn);
    chk("ignore_bcd", 32'(bcd_out), 32'h01234);
    dcount = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clock); #1;
      if (done) dcount++;
    end
    chk("ignore_no_second_done", 32'(dcount), 32'd0);

    // Start in the done cycle: back-to-back at BIN_W+2 period.
    accept(16'd7);
    wait_done(40, n, bn);
    chk("b2b_first_bcd", 32'(bcd_out), 32'h00007);
    bin = 16'd40960; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    wait_done(40, n, bn);
    chk("b2b_spacing", 32'(n + 1), 32'd18);
    chk("b2b_second_bcd", 32'(bcd_out), 32'h40960);

    // Asynchronous reset mid-conversion.
    accept(16'd5555);
    repeat (8) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_bcd",  32'(bcd_out), 32'd0);
    #2 reset_n = 1'b1;
    @(posedge clock); #1;
    accept(16'd42);
    wait_done(40, n, bn);
    chk("after_rst_bcd", 32'(bcd_out), 32'h00042);

    // Random conversions with noisy start/bin/digit_idx while busy.
    for (int c = 0; c < 2000; c++) begin
      case ($urandom_range(0, 9))
        0:       bin = 16'd0;
        1:       bin = 16'hFFFF;
        default: bin = 16'($urandom_range(0, 65535));
      endcase
      start = 1'b1;
      @(posedge clock); #1;
      n = 0;
      dcount = 0;
      while (!done && n < 40) begin
        start     = 1'($urandom_range(0, 1));
        bin       = 16'($urandom_range(0, 65535));
        digit_idx = 3'($urandom_range(0, 7));
        @(posedge clock); #1;
        n++;
      end
      chk("rand_latency", 32'(n), 32'd17);
    end
    start = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_bm_bin2bcd_seq

// File: doc/bm_bin2bcd_seq.md
Name: bm_bin2bcd_seq

Overview:
- Sequential binary-to-BCD converter using iterative shift-and-add-3 (double-dabble), one binary bit per clock.
- Sits directly upstream of the seven-segment BCD decoder.
- Produces a registered packed BCD result, plus a per-digit nibble select (bcd_digit) that feeds the decoder's 4-bit bcd input.
- Start/busy/done handshake toward the producer of the binary value.

Parameters:
- BIN_W, 16, width of the binary input.
- DIGITS, 5, number of BCD digits; must satisfy 10^DIGITS > 2^BIN_W - 1, so no overflow is possible.
- IDX_W, 3, width of digit_idx; must satisfy 2^IDX_W >= DIGITS.

Ports:
- clock  input  1  single rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  request conversion of bin; sampled only in IDLE.
- bin  input  BIN_W  unsigned binary value, captured on the accepting edge.
- busy  output  1  high while a conversion is in progress (SHIFT or DONE state).
- done  output  1  one-cycle pulse; bcd_out is valid and updated when it is high.
- bcd_out  output  4*DIGITS  packed BCD result, digit 0 (units) in bits [3:0].
- digit_idx  input  IDX_W  selects one digit for bcd_digit.
- bcd_digit  output  4  combinational select of bcd_out[4*digit_idx+3 : 4*digit_idx]; 4'hF when digit_idx >= DIGITS.

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE.
  - busy = 0, done = 0, bcd_out = 0; internal shift register and counter = 0.
  - Takes effect immediately, including mid-conversion; the partial result is discarded and bcd_out reads 0.
- States: IDLE, SHIFT, DONE. All outputs except bcd_digit are registered.
- IDLE:
  - On an edge with start = 1: capture bin into the binary shift register, clear the BCD scratch, load bit counter = BIN_W-1, go to SHIFT.
  - busy rises after this edge.
- SHIFT, every edge:
  - For each scratch digit >= 5, add 3 (4-bit wrap not reachable).
  - Then shift the {scratch, binary} concatenation left by 1; the MSB of binary enters scratch bit 0.
  - When counter == 0 on this edge, go to DONE; otherwise decrement the counter.
  - Exactly BIN_W SHIFT edges per conversion.
- DONE, next edge:
  - bcd_out <= scratch, done <= 1, busy <= 0, state = IDLE.
  - done drops on the following edge unless a new conversion completes.
- Latency: with start accepted at edge k, the SHIFT edges are k+1..k+BIN_W. bcd_out updates and done goes high after edge k+BIN_W+1, so the cycle after edge 18 for BIN_W=16.
- start while busy: ignored, no queuing. bin changes while busy: ignored.
- start high in the cycle done is high: state is IDLE, so the request is accepted and back-to-back throughput is 1 result per BIN_W+2 cycles. done still pulses for only one cycle.
- start held high continuously: conversions repeat back-to-back, each re-sampling bin at acceptance.
- bcd_out holds the last result until the next done; it never shows intermediate values.
- bcd_digit is purely combinational from bcd_out and digit_idx; the out-of-range value 4'hF drives the decoder's default pattern.

Decomposition:
- Shared package bm_bcd_pkg:
  - state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2);
  - ADD3_THRESHOLD = 4'd5;
  - BLANK_NIBBLE = 4'hF;
  - default BIN_W/DIGITS.
- One natural sub-module, bm_bcd_add3: combinational 4-bit correction (in >= 5 ? in+3 : in), instantiated DIGITS times in a generate loop.

Test Plan:
- bin=16'd0, start pulse -> done pulse after edge 18, bcd_out=20'h00000, busy high exactly across the 17 cycles between acceptance and done.
- bin=16'd65535 -> bcd_out=20'h65535. Sweep digit_idx 0..4 -> bcd_digit 5,3,5,5,6; digit_idx 5/6/7 -> 4'hF.
- bin=16'd1234, then raise start again with bin=16'd9999 in cycle 5 -> second start ignored, bcd_out=20'h01234, no second done.
- start asserted in the done cycle with bin=16'd40960 after a 16'd7 conversion -> first bcd_out=20'h00007, then 20'h40960 exactly 18 edges later.
- reset_n pulsed low at SHIFT cycle 8 of bin=16'd5555 -> busy=0, done=0, bcd_out=0 immediately; a fresh start with 16'd42 afterwards -> 20'h00042.
- Random bin over 2000 conversions vs. a reference model; check done never lasts more than one cycle and busy never overlaps done.
